// File: rtl/slow_memory_pkg.sv
// Shared types and default widths for the fixed-latency line memory model.
package slow_memory_pkg;

    localparam int SMM_ADDR_W = 28;
    localparam int SMM_DATA_W = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

endpackage

// File: rtl/slow_mem_lat_ctr.sv
// Loadable down-counter with zero flag; times the BUSY phase of a memory request.
module slow_mem_lat_ctr #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    // Saturates at zero so a stalled decrement never wraps to all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/slow_memory_model.sv
// Fixed-latency 128-bit line memory with level request / one-cycle ready handshake.
// Optional protocol checker enabled by defining SLOW_MEM_PROTO_CHECK_EN (adds proto_err).
module slow_memory_model
    import slow_memory_pkg::*;
#(
    parameter int LATENCY = 10,
    parameter int ADDR_W  = SMM_ADDR_W,
    parameter int DATA_W  = SMM_DATA_W,
    parameter int DEPTH   = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready
`ifdef SLOW_MEM_PROTO_CHECK_EN
    ,
    output logic              proto_err
`endif
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CTR_W = $clog2(LATENCY + 1);

    // Storage is deliberately left out of reset so backdoor preloads survive.
    logic [DATA_W-1:0] mem [DEPTH];

    state_t            r_state;
    op_t               r_op;
    logic [IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;

    logic w_req;
    logic w_start;
    logic w_abort;
    logic w_done;
    logic w_commit_wr;
    logic w_ctr_zero;
    logic w_unused_addr_hi;

    assign w_req       = mem_read | mem_write;
    assign w_start     = (r_state == IDLE) && w_req;
    assign w_abort     = (r_state == BUSY) && !w_req;
    assign w_done      = (r_state == BUSY) && w_req && w_ctr_zero;
    assign w_commit_wr = w_done && (r_op == OP_WRITE);

    // Upper line-address bits alias onto the array.
    assign w_unused_addr_hi = ^mem_addr[ADDR_W-1:IDX_W];

    slow_mem_lat_ctr #(
        .WIDTH(CTR_W)
    ) u_lat_ctr (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_start),
        .i_load_val(CTR_W'(LATENCY - 1)),
        .i_dec     (r_state == BUSY),
        .o_zero    (w_ctr_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_op    <= OP_READ;
            r_idx   <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        // Write wins when both requests are raised together.
                        r_op    <= mem_write ? OP_WRITE : OP_READ;
                        r_idx   <= mem_addr[IDX_W-1:0];
                        r_wdata <= mem_wdata;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (w_abort) begin
                        r_state <= IDLE;
                    end else if (w_ctr_zero) begin
                        r_rdata <= (r_op == OP_WRITE) ? '0 : mem[r_idx];
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_commit_wr) begin
            mem[r_idx] <= r_wdata;
        end
    end

    assign mem_rdata = r_rdata;
    assign mem_ready = (r_state == RESP);

`ifdef SLOW_MEM_PROTO_CHECK_EN
    logic [ADDR_W-1:0] r_addr;
    logic              r_proto_err;
    op_t               w_req_op;
    logic              w_viol;

    assign w_req_op = mem_write ? OP_WRITE : OP_READ;
    assign w_viol   = (mem_read & mem_write) | w_abort |
                      ((r_state == BUSY) && w_req &&
                       ((w_req_op != r_op) || (mem_addr != r_addr)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr      <= '0;
            r_proto_err <= 1'b0;
        end else begin
            if (w_start) begin
                r_addr <= mem_addr;
            end
            if (w_viol) begin
                r_proto_err <= 1'b1;
`ifndef SYNTHESIS
                $display("[slow_memory_model] protocol violation at %0t: rd=%0b wr=%0b addr=%0h state=%0d",
                         $time, mem_read, mem_write, mem_addr, r_state);
`endif
            end
        end
    end

    assign proto_err = r_proto_err;
`endif

endmodule

// File: tb/tb_slow_memory_model.sv
// Directed self-checking bench for slow_memory_model (default LATENCY=10, DEPTH=1024).
module tb_slow_memory_model;
    import slow_memory_pkg::*;

    localparam int ADDR_W = 28;
    localparam int DATA_W = 128;

    logic              clk;
    logic              rst_n;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
`ifdef SLOW_MEM_PROTO_CHECK_EN
    logic              proto_err;
`endif

    int tests_run;
    int tests_failed;

    localparam logic [DATA_W-1:0] PRE5 = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [DATA_W-1:0] PRE9 = 128'h99990000999900009999000099990000;
    localparam logic [DATA_W-1:0] DA5  = {16{8'hA5}};

    slow_memory_model dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready)
`ifdef SLOW_MEM_PROTO_CHECK_EN
        ,
        .proto_err(proto_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge with the request already driven; n counts posedges seen.
    task automatic wait_ready(input int max, output int edge_n, output logic [DATA_W-1:0] data);
        edge_n = -1;
        data   = '0;
        for (int n = 0; n <= max; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (mem_ready) begin
                edge_n = n;
                data   = mem_rdata;
                return;
            end
        end
    endtask

    task automatic drop_req();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0; mem_addr = '0; mem_wdata = '0;
        dut.mem[5] <= PRE5;
        dut.mem[9] <= PRE9;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (mem_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ready got=%0b want=0", mem_ready);
        end
        tests_run++;
        if (mem_rdata !== '0) begin
            tests_failed++;
            $display("FAIL reset_rdata got=%h want=0", mem_rdata);
        end
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        $display("[TB] reset released");
    endtask

    task automatic test_read();
        int n;
        logic [DATA_W-1:0] d;
        mem_read = 1'b1; mem_addr = 28'd5;
        wait_ready(30, n, d);
        $display("[TB] read addr 5 ready_edge=%0d data=%h", n, d);
        tests_run++;
        if (n !== 10) begin
            tests_failed++;
            $display("FAIL read_latency got=%0d want=10", n);
        end
        tests_run++;
        if (d !== PRE5) begin
            tests_failed++;
            $display("FAIL read_data got=%h want=%h", d, PRE5);
        end
        drop_req();
        tests_run++;
        if (mem_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL read_pulse_width got=%0b want=0", mem_ready);
        end
    endtask

    task automatic test_write_read();
        int n;
        logic [DATA_W-1:0] d;
        mem_write = 1'b1; mem_addr = 28'd7; mem_wdata = DA5;
        wait_ready(30, n, d);
        $display("[TB] write addr 7 ready_edge=%0d rdata=%h", n, d);
        tests_run++;
        if (n !== 10 || d !== '0) begin
            tests_failed++;
            $display("FAIL write_resp got edge=%0d data=%h want edge=10 data=0", n, d);
        end
        // Read raised during RESP: one idle edge, then 10 cycles.
        mem_write = 1'b0; mem_read = 1'b1; mem_wdata = '0;
        wait_ready(30, n, d);
        $display("[TB] read addr 7 ready_edge=%0d data=%h", n, d);
        tests_run++;
        if (n !== 11) begin
            tests_failed++;
            $display("FAIL wr_rd_latency got=%0d want=11", n);
        end
        tests_run++;
        if (d !== DA5) begin
            tests_failed++;
            $display("FAIL wr_rd_data got=%h want=%h", d, DA5);
        end
        drop_req();
    endtask

    task automatic test_back_to_back();
        int pulses;
        int last;
        pulses = 0; last = -1;
        mem_read = 1'b1; mem_addr = 28'd5;
        for (int n = 0; n <= 22; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (mem_ready) begin
                pulses++;
                last = n;
            end
        end
        $display("[TB] back_to_back pulses=%0d last_edge=%0d", pulses, last);
        tests_run++;
        if (pulses !== 2 || last !== 22) begin
            tests_failed++;
            $display("FAIL back_to_back got pulses=%0d last=%0d want pulses=2 last=22", pulses, last);
        end
        drop_req();
    endtask

    task automatic test_both_high();
        int n;
        logic [DATA_W-1:0] d;
        mem_read = 1'b1; mem_write = 1'b1; mem_addr = 28'd3; mem_wdata = 128'h1;
        wait_ready(30, n, d);
        drop_req();
        $display("[TB] both_high addr 3 ready_edge=%0d mem3=%h", n, dut.mem[3]);
        tests_run++;
        if (n !== 10 || d !== '0) begin
            tests_failed++;
            $display("FAIL both_high_resp got edge=%0d data=%h want edge=10 data=0", n, d);
        end
        tests_run++;
        if (dut.mem[3] !== 128'h1) begin
            tests_failed++;
            $display("FAIL both_high_mem got=%h want=1", dut.mem[3]);
        end
`ifdef SLOW_MEM_PROTO_CHECK_EN
        tests_run++;
        if (proto_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL proto_err got=%0b want=1", proto_err);
        end
`endif
    endtask

    task automatic test_abort();
        int pulses;
        pulses = 0;
        mem_write = 1'b1; mem_addr = 28'd9; mem_wdata = DA5;
        @(posedge clk);           // accepted
        repeat (4) @(posedge clk);
        @(negedge clk);
        mem_write = 1'b0; mem_wdata = '0;
        for (int n = 0; n < 15; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (mem_ready) pulses++;
        end
        $display("[TB] aborted write addr 9 pulses=%0d mem9=%h", pulses, dut.mem[9]);
        tests_run++;
        if (pulses !== 0) begin
            tests_failed++;
            $display("FAIL abort_ready got=%0d want=0", pulses);
        end
        tests_run++;
        if (dut.mem[9] !== PRE9) begin
            tests_failed++;
            $display("FAIL abort_mem got=%h want=%h", dut.mem[9], PRE9);
        end
    endtask

    task automatic test_async_reset();
        int n;
        logic [DATA_W-1:0] d;
        // Reset mid-BUSY write: pending write discarded.
        mem_write = 1'b1; mem_addr = 28'd9; mem_wdata = DA5;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (mem_ready !== 1'b0 || dut.r_state !== IDLE) begin
            tests_failed++;
            $display("FAIL reset_busy got ready=%0b state=%0d want ready=0 state=0", mem_ready, dut.r_state);
        end
        @(negedge clk);
        mem_write = 1'b0; mem_wdata = '0;
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        @(negedge clk);
        $display("[TB] reset mid-write addr 9 mem9=%h", dut.mem[9]);
        tests_run++;
        if (dut.mem[9] !== PRE9) begin
            tests_failed++;
            $display("FAIL reset_write_discard got=%h want=%h", dut.mem[9], PRE9);
        end
        // Reset while the ready pulse is high drops it immediately.
        mem_read = 1'b1; mem_addr = 28'd5;
        wait_ready(30, n, d);
        #1 rst_n = 1'b0;
        #1;
        $display("[TB] reset during ready edge=%0d ready=%0b rdata=%h", n, mem_ready, mem_rdata);
        tests_run++;
        if (n !== 10 || mem_ready !== 1'b0 || mem_rdata !== '0) begin
            tests_failed++;
            $display("FAIL reset_resp got edge=%0d ready=%0b rdata=%h want edge=10 ready=0 rdata=0",
                     n, mem_ready, mem_rdata);
        end
        @(negedge clk);
        mem_read = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (dut.mem[5] !== PRE5) begin
            tests_failed++;
            $display("FAIL reset_mem_intact got=%h want=%h", dut.mem[5], PRE5);
        end
    endtask

    task automatic test_alias();
        int n;
        logic [DATA_W-1:0] d;
        mem_read = 1'b1; mem_addr = 28'd1029;
        wait_ready(30, n, d);
        $display("[TB] read addr 1029 ready_edge=%0d data=%h", n, d);
        tests_run++;
        if (n !== 10 || d !== PRE5) begin
            tests_failed++;
            $display("FAIL alias got edge=%0d data=%h want edge=10 data=%h", n, d, PRE5);
        end
        drop_req();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_read();
        test_write_read();
        test_back_to_back();
        test_both_high();
        test_abort();
        test_alias();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
